i2s_to_pcm_converter: RTL and testbench
=======================================

// Module: i2s_to_pcm_converter
// PURPOSE
//  Receive path counterpart of the PCM-to-I2S transmitter. Oversamples an external I2S stream
//  (bclk_in, lrclk_in, s_data_in) on the system clk (49.152 MHz) and recovers 24-bit left/right
//  PCM words, one valid strobe per word. Sits between the ADC/I2S input pins and the DSP chain.
// PARAMETERS
//  DATA_WIDTH   24  PCM word width; MSB-first capture
//  SLOT_BITS    32  bclk periods per channel slot (64 per lrclk frame)
//  SYNC_STAGES  2   flip-flop stages on each async input (min 2)
// PORTS
//  clk           in   1   system clock, 49.152 MHz; bclk_in must be <= clk/4
//  reset_n       in   1   synchronous, active-low reset
//  bclk_in       in   1   external I2S bit clock (async to clk)
//  lrclk_in      in   1   external word select: 0 = left, 1 = right (async)
//  s_data_in     in   1   external serial data, I2S standard format (async)
//  l_data        out  24  last complete left word, held until next left word
//  r_data        out  24  last complete right word, held until next right word
//  l_data_valid  out  1   1-clk pulse: l_data updated this cycle
//  r_data_valid  out  1   1-clk pulse: r_data updated this cycle
//  frame_err     out  1   1-clk pulse: slot length violation detected
//  locked        out  1   high while receiving well-formed slots
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk): l_data=r_data=0, all strobes=0, locked=0, state=HUNT,
//   bit_cnt=0, shift reg=0, synchronisers cleared to 0. Reset mid-slot discards the partial word.
//  Front end: each input passes SYNC_STAGES flops; bclk rise = (sync bclk==1 && prev==0).
//   All capture happens only on clk cycles flagged as bclk rise; other cycles hold state.
//  On each bclk rise, sample lrclk_s and s_data_s together. lr_edge = lrclk_s != lrclk_prev.
//  States:
//   HUNT  - ignore data; on lr_edge -> LEFT if lrclk_s=0, RIGHT if lrclk_s=1; bit_cnt=0.
//   LEFT/RIGHT - bit_cnt increments per bclk rise (saturates at SLOT_BITS+1).
//     The rise carrying lr_edge is bit 0 (last bit of previous slot, I2S 1-bit delay): not stored.
//     Rises 1..DATA_WIDTH shift s_data_s in MSB-first.
//     When bit DATA_WIDTH is shifted: on next clk, load l_data (LEFT) or r_data (RIGHT),
//      pulse the matching valid for exactly one clk.
//     Rises DATA_WIDTH+1..SLOT_BITS-1: data ignored (padding).
//     lr_edge with bit_cnt == SLOT_BITS-1: well-formed; switch channel, bit_cnt=0, locked=1.
//     lr_edge with bit_cnt != SLOT_BITS-1: frame_err pulse, locked=0, -> HUNT.
//     bit_cnt reaches SLOT_BITS without lr_edge: frame_err pulse, locked=0, -> HUNT.
//     lr_edge direction inconsistent with state (e.g. LEFT sees lrclk_s=0): cannot occur by
//      construction; lr_edge always toggles channel.
//  locked rises on the first well-formed slot boundary after HUNT; first word after HUNT is
//   emitted (its slot started on a detected edge) even though locked is still 0.
//  Latency: valid asserted 1 clk after the clk cycle whose bclk rise captured the LSB
//   (plus SYNC_STAGES+1 clk from the pin).
//  Simultaneous: word-complete and frame_err never share a cycle; error on a slot whose word
//   was already emitted does not retract the word. l_data/r_data never change without valid.
// TESTING
//  1 reset_n=0 for 4 clk with toggling inputs -> all outputs 0, locked=0, no strobes.
//  2 model TX at bclk=clk/8, 64 bclk/frame, L=24'hA5A5A5, R=24'h5A5A5A, 3 frames ->
//    l_data_valid/r_data_valid alternate, each one clk wide, data exact; locked=1 after 1st slot.
//  3 L=24'h800000, R=24'h7FFFFF then L=24'h000001, R=24'hFFFFFF -> exact words, no sign/bit slip.
//  4 lrclk toggles after 10 bclk in a left slot -> one frame_err, no l_data_valid, locked=0;
//    relock and correct words from the following frame.
//  5 lrclk held 40 bclk -> word emitted once at bit 24, frame_err at bit 32, HUNT, then recovery.
//  6 reset_n=0 mid right slot (bit 12) for 1 clk -> no r_data_valid for that slot, outputs 0,
//    next full slot decoded correctly.

Source files
------------

// File: rtl/i2s_to_pcm_converter.sv
// i2s_to_pcm_converter
//   Oversamples an external I2S stream on the system clock and recovers left/right PCM words.
//   Each channel slot is SLOT_BITS bit clocks long. The first DATA_WIDTH bits after the slot's
//   one-bit I2S delay are captured MSB-first. Slot length violations pulse frame_err and drop
//   the receiver back to hunting for the next word-select edge.
// Ports
//   clk           system clock (bclk_in must be <= clk/4)
//   reset_n       synchronous active-low reset
//   bclk_in       I2S bit clock, asynchronous
//   lrclk_in      I2S word select (0 = left, 1 = right), asynchronous
//   s_data_in     I2S serial data, asynchronous
//   l_data        last complete left word, held until the next one
//   r_data        last complete right word, held until the next one
//   l_data_valid  one-clk pulse when l_data is updated
//   r_data_valid  one-clk pulse when r_data is updated
//   frame_err     one-clk pulse on a slot length violation
//   locked        high while well-formed slots are being received
module i2s_to_pcm_converter #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bclk_in,
    input  logic                  lrclk_in,
    input  logic                  s_data_in,
    output logic [DATA_WIDTH-1:0] l_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  l_data_valid,
    output logic                  r_data_valid,
    output logic                  frame_err,
    output logic                  locked
);

    localparam int unsigned CntW = $clog2(SLOT_BITS + 2);

    localparam logic [CntW-1:0] CntWord = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(SLOT_BITS - 1);
    localparam logic [CntW-1:0] CntSlot = CntW'(SLOT_BITS);
    localparam logic [CntW-1:0] CntMax  = CntW'(SLOT_BITS + 1);

    localparam logic [1:0] StHunt  = 2'd0;
    localparam logic [1:0] StLeft  = 2'd1;
    localparam logic [1:0] StRight = 2'd2;

    // Input synchronisers
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;

    logic bclk_s;
    logic lrclk_s;
    logic sdata_s;

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign lrclk_s = lrclk_sync[SYNC_STAGES-1];
    assign sdata_s = sdata_sync[SYNC_STAGES-1];

    // State
    logic                  bclk_prev_q;
    logic                  lrclk_prev_q, lrclk_prev_d;
    logic                  primed_q, primed_d;
    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] l_data_d, r_data_d;
    logic                  l_valid_d, r_valid_d, err_d, locked_d;

    logic                  bclk_rise;
    logic                  lr_edge;
    logic [CntW-1:0]       cnt_inc;
    logic [DATA_WIDTH-1:0] word;

    assign bclk_rise = bclk_s && !bclk_prev_q;
    assign lr_edge   = lrclk_s != lrclk_prev_q;
    assign cnt_inc   = (bit_cnt_q == CntMax) ? bit_cnt_q : bit_cnt_q + 1'b1;
    assign word      = {shift_q, sdata_s};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        lrclk_prev_d = lrclk_prev_q;
        primed_d     = primed_q;
        locked_d     = locked;
        l_data_d     = l_data;
        r_data_d     = r_data;
        l_valid_d    = 1'b0;
        r_valid_d    = 1'b0;
        err_d        = 1'b0;

        if (bclk_rise) begin
            lrclk_prev_d = lrclk_s;
            primed_d     = 1'b1;
            // The first rise after reset only learns the current lrclk level, so a reset in
            // the middle of a slot never looks like a fresh slot boundary.
            if (primed_q) begin
                case (state_q)
                    StHunt: begin
                        if (lr_edge) begin
                            state_d   = lrclk_s ? StRight : StLeft;
                            bit_cnt_d = '0;
                        end
                    end
                    StLeft, StRight: begin
                        if (lr_edge) begin
                            bit_cnt_d = '0;
                            if (bit_cnt_q == CntLast) begin
                                state_d  = (state_q == StLeft) ? StRight : StLeft;
                                locked_d = 1'b1;
                            end else begin
                                state_d  = StHunt;
                                err_d    = 1'b1;
                                locked_d = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = cnt_inc;
                            // Rise 0 carries the previous slot's last bit; rises 1..DATA_WIDTH
                            // carry the word, anything after is padding.
                            if (cnt_inc < CntWord) begin
                                shift_d = {shift_q[DATA_WIDTH-3:0], sdata_s};
                            end
                            if (cnt_inc == CntWord) begin
                                if (state_q == StLeft) begin
                                    l_data_d  = word;
                                    l_valid_d = 1'b1;
                                end else begin
                                    r_data_d  = word;
                                    r_valid_d = 1'b1;
                                end
                            end
                            if (cnt_inc == CntSlot) begin
                                state_d   = StHunt;
                                bit_cnt_d = '0;
                                err_d     = 1'b1;
                                locked_d  = 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_d   = StHunt;
                        bit_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_sync    <= '0;
            lrclk_sync   <= '0;
            sdata_sync   <= '0;
            bclk_prev_q  <= 1'b0;
            lrclk_prev_q <= 1'b0;
            primed_q     <= 1'b0;
            state_q      <= StHunt;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            l_data       <= '0;
            r_data       <= '0;
            l_data_valid <= 1'b0;
            r_data_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], bclk_in};
            lrclk_sync   <= {lrclk_sync[SYNC_STAGES-2:0], lrclk_in};
            sdata_sync   <= {sdata_sync[SYNC_STAGES-2:0], s_data_in};
            bclk_prev_q  <= bclk_s;
            lrclk_prev_q <= lrclk_prev_d;
            primed_q     <= primed_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            l_data       <= l_data_d;
            r_data       <= r_data_d;
            l_data_valid <= l_valid_d;
            r_data_valid <= r_valid_d;
            frame_err    <= err_d;
            locked       <= locked_d;
        end
    end

endmodule

// File: tb/tb_i2s_to_pcm_converter.sv
// tb_i2s_to_pcm_converter
//   Drives slot-level I2S traffic (bclk = clk/8) and compares the recovered words, frame errors
//   and lock state against a slot-level reference model.
module tb_i2s_to_pcm_converter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bclk_in = 1'b0;
    logic        lrclk_in = 1'b0;
    logic        s_data_in = 1'b0;
    logic [23:0] l_data;
    logic [23:0] r_data;
    logic        l_data_valid;
    logic        r_data_valid;
    logic        frame_err;
    logic        locked;

    i2s_to_pcm_converter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bclk_in      (bclk_in),
        .lrclk_in     (lrclk_in),
        .s_data_in    (s_data_in),
        .l_data       (l_data),
        .r_data       (r_data),
        .l_data_valid (l_data_valid),
        .r_data_valid (r_data_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slot-level reference model
    typedef struct packed {
        logic        ch;
        logic [23:0] data;
    } word_t;

    word_t       exp_q[$];
    bit          m_primed = 0;
    bit          m_tracked = 0;
    bit          m_locked = 0;
    int          m_len = 0;
    int          m_err = 0;
    int          dut_err = 0;
    bit          cur_ch = 0;
    logic        rst_q = 1'b0;
    logic [23:0] exp_l = '0;
    logic [23:0] exp_r = '0;

    // One channel slot of `len` bit clocks; the word select toggles at its start.
    task automatic send_slot(input int len, input logic [23:0] word, input int reset_at);
        bit nt;
        cur_ch = ~cur_ch;
        // The edge opening this slot closes the previous one.
        if (!m_primed) nt = 0;
        else if (!m_tracked) nt = 1;
        else if (m_len == 32) begin
            m_locked = 1;
            nt = 1;
        end else if (m_len < 32) begin
            m_err++;
            m_locked = 0;
            nt = 0;
        end else nt = 1;
        m_primed = 1;
        if (reset_at >= 0) begin
            nt = 0;
            m_locked = 0;
        end
        m_tracked = nt;
        m_len = len;
        if (nt && len >= 25) exp_q.push_back({cur_ch, word});
        if (nt && len > 32) begin
            m_err++;
            m_locked = 0;
        end
        for (int k = 0; k < len; k++) begin
            bclk_in = 1'b0;
            lrclk_in = cur_ch;
            s_data_in = (k >= 1 && k <= 24) ? word[24-k] : 1'($urandom);
            if (k == reset_at) begin
                #10 reset_n = 1'b0;
                #10 reset_n = 1'b1;
                #20;
            end else begin
                #40;
            end
            bclk_in = 1'b1;
            #40;
        end
    endtask

    task automatic checkpoint(input string tag);
        repeat (8) @(posedge clk);
        #1;
        check_eq({tag, "_pending_words"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_frame_errs"}, 64'(dut_err), 64'(m_err));
        check_eq({tag, "_locked"}, 64'(locked), 64'(m_locked));
    endtask

    always @(posedge clk) rst_q <= reset_n;

    always @(negedge clk) begin
        if (!rst_q) begin
            exp_l = '0;
            exp_r = '0;
            check_eq("reset_outputs",
                     {l_data, r_data, l_data_valid, r_data_valid, frame_err, locked}, 64'd0);
        end else begin
            if (frame_err) dut_err++;
            if (l_data_valid || r_data_valid) begin
                check_eq("word_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    word_t w;
                    w = exp_q.pop_front();
                    check_eq("word", {l_data_valid, r_data_valid, (r_data_valid ? r_data : l_data)},
                             {~w.ch, w.ch, w.data});
                    if (w.ch) exp_r = w.data;
                    else exp_l = w.data;
                end
            end
            check_eq("l_hold", l_data, exp_l);
            check_eq("r_hold", r_data, exp_r);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with toggling inputs
        repeat (4) begin
            @(posedge clk);
            #2;
            bclk_in = 1'($urandom);
            lrclk_in = 1'($urandom);
            s_data_in = 1'($urandom);
        end
        bclk_in = 1'b0;
        lrclk_in = 1'b0;
        s_data_in = 1'b0;
        cur_ch = 0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        checkpoint("after_reset");

        // Lead-in partial right slot, then three nominal frames
        send_slot(8, 24'h0, -1);
        for (int f = 0; f < 3; f++) begin
            send_slot(32, 24'hA5A5A5, -1);
            send_slot(32, 24'h5A5A5A, -1);
        end
        checkpoint("nominal");

        // Boundary words
        send_slot(32, 24'h800000, -1);
        send_slot(32, 24'h7FFFFF, -1);
        send_slot(32, 24'h000001, -1);
        send_slot(32, 24'hFFFFFF, -1);
        checkpoint("extremes");

        // Short left slot
        send_slot(10, 24'h123456, -1);
        send_slot(32, 24'h654321, -1);
        checkpoint("short_slot");
        send_slot(32, 24'h13579B, -1);
        send_slot(32, 24'h2468AC, -1);
        checkpoint("short_recover");

        // Long left slot
        send_slot(40, 24'hC0FFEE, -1);
        checkpoint("long_slot");
        send_slot(32, 24'hBADA55, -1);
        send_slot(32, 24'h0F0F0F, -1);
        send_slot(32, 24'hF0F0F0, -1);
        checkpoint("long_recover");

        // Reset in the middle of a right slot
        send_slot(32, 24'h111111, -1);
        send_slot(32, 24'h222222, 12);
        checkpoint("mid_reset");
        send_slot(32, 24'h333333, -1);
        send_slot(32, 24'h444444, -1);
        checkpoint("reset_recover");

        // Random words with occasional malformed slot lengths
        for (int i = 0; i < 16; i++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : 32;
            send_slot(len, 24'($urandom), -1);
        end
        checkpoint("random");
        send_slot(32, 24'($urandom), -1);
        send_slot(32, 24'($urandom), -1);
        send_slot(32, 24'($urandom), -1);
        checkpoint("random_tail");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
